// File: rtl/scene_sequencer.sv
// ============================================================================
// Module      : scene_sequencer
// Description : Frame-synchronous scene controller that drives background_state
//               and solid_color. It steps scenes on a frame dwell, with pause
//               and skip controls. Optional macro SCENE_RANDOM_EN selects
//               LFSR-driven scene order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scene_sequencer #(
    parameter int NUM_SCENES   = 11,
    parameter int DWELL_FRAMES = 120,
    parameter int V_LAST       = 524
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] vpos,
    input  logic       pause,
    input  logic       skip,
    output logic [7:0] background_state,
    output logic [5:0] solid_color,
    output logic [9:0] moving_counter,
    output logic       scene_change,
    output logic       running
);

    localparam logic [7:0] LAST_SCENE = 8'(NUM_SCENES - 1);
    localparam logic [7:0] LAST_FRAME = 8'(DWELL_FRAMES - 1);
    localparam logic [5:0] RESET_COLOR = 6'b110000;

    if (NUM_SCENES < 1 || NUM_SCENES > 256) begin : g_bad_num_scenes
        $error("scene_sequencer: NUM_SCENES must be in 1..256");
    end
    if (DWELL_FRAMES < 1 || DWELL_FRAMES > 255) begin : g_bad_dwell
        $error("scene_sequencer: DWELL_FRAMES must be in 1..255");
    end
    if (V_LAST < 1 || V_LAST > 1023) begin : g_bad_vlast
        $error("scene_sequencer: V_LAST must fit the 10-bit vpos");
    end

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        RUN        = 2'd1,
        PAUSE      = 2'd2
    } state_t;

    state_t     state_q;
    logic [9:0] prev_vpos_q;
    logic [7:0] frame_cnt_q;
    logic [1:0] pal_idx_q;
    logic       skip_pending_q;
    logic [7:0] scene_q;
    logic [5:0] color_q;
    logic [9:0] mcnt_q;
    logic       scene_change_q;
    logic       running_q;

    logic       frame_tick;
    logic       skip_req;
    logic       advance;
    logic [7:0] seq_scene;
    logic [7:0] scene_d;
    logic [1:0] pal_d;

    function automatic logic [5:0] palette(input logic [1:0] idx);
        logic [5:0] col;
        case (idx)
            2'd0:    col = 6'b110000;
            2'd1:    col = 6'b001100;
            2'd2:    col = 6'b000011;
            default: col = 6'b111111;
        endcase
        return col;
    endfunction

`ifdef SCENE_RANDOM_EN
    logic [6:0] lfsr_q;
    logic [7:0] rnd_scene;

    // x^7 + x^6 + 1, advanced once per frame tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 7'h5A;
        end else if (frame_tick) begin
            lfsr_q <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        end
    end

    always_comb begin
        rnd_scene = 8'({25'd0, lfsr_q} % 32'(NUM_SCENES));
        seq_scene = (scene_q == LAST_SCENE) ? 8'd0 : scene_q + 8'd1;
        scene_d   = (rnd_scene == scene_q) ? seq_scene : rnd_scene;
    end
`else
    always_comb begin
        seq_scene = (scene_q == LAST_SCENE) ? 8'd0 : scene_q + 8'd1;
        scene_d   = seq_scene;
    end
`endif

    // A skip arriving in the tick cycle itself is serviced by that tick.
    always_comb begin
        frame_tick = (vpos == 10'd0) && (prev_vpos_q != 10'd0);
        skip_req   = skip_pending_q | skip;
        advance    = frame_tick &&
                     (skip_req ||
                      ((state_q == RUN) && !pause && (frame_cnt_q == LAST_FRAME)));
        pal_d      = pal_idx_q + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= WAIT_FRAME;
            prev_vpos_q    <= 10'd0;
            frame_cnt_q    <= 8'd0;
            pal_idx_q      <= 2'd0;
            skip_pending_q <= 1'b0;
            scene_q        <= 8'd0;
            color_q        <= RESET_COLOR;
            mcnt_q         <= 10'd0;
            scene_change_q <= 1'b0;
            running_q      <= 1'b0;
        end else begin
            prev_vpos_q    <= vpos;
            scene_change_q <= 1'b0;
            if (frame_tick) begin
                skip_pending_q <= 1'b0;
                if (advance) begin
                    scene_q        <= scene_d;
                    frame_cnt_q    <= 8'd0;
                    scene_change_q <= 1'b1;
                    if (scene_d == 8'd0) begin
                        pal_idx_q <= pal_d;
                        color_q   <= palette(pal_d);
                    end
                end
                case (state_q)
                    WAIT_FRAME: begin
                        state_q   <= pause ? PAUSE : RUN;
                        running_q <= !pause;
                    end
                    RUN: begin
                        if (pause) begin
                            state_q   <= PAUSE;
                            running_q <= 1'b0;
                        end else begin
                            mcnt_q <= mcnt_q + 10'd1;
                            if (!advance) begin
                                frame_cnt_q <= frame_cnt_q + 8'd1;
                            end
                        end
                    end
                    PAUSE: begin
                        if (!pause) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= WAIT_FRAME;
                        running_q <= 1'b0;
                    end
                endcase
            end else if (skip) begin
                skip_pending_q <= 1'b1;
            end
        end
    end

    assign background_state = scene_q;
    assign solid_color      = color_q;
    assign moving_counter   = mcnt_q;
    assign scene_change     = scene_change_q;
    assign running          = running_q;

endmodule

`default_nettype wire
